// File: rtl/pri_enc_pkg.sv
// Shared constants and helpers for the parametrised priority encoder.
package pri_enc_pkg;

  localparam logic        MODE_FIXED = 1'b0;
  localparam logic        MODE_RR    = 1'b1;
  localparam int unsigned PC_MAX_W   = 1024;

  // Clearing the lowest set bit leaves a non-zero value only when two or more bits are set.
  function automatic logic popcount_gt1(input logic [PC_MAX_W-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/pri_find_first.sv
// Combinational search for the first set bit of vec, starting at start and wrapping.
module pri_find_first #(
  parameter  int unsigned N     = 8,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  // The doubled vector makes the rotate a plain shift; start is always below N.
  always_comb begin
    dbl   = {vec, vec} >> start;
    rot   = dbl[N-1:0];
    found = |vec;
    off   = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (rot[i-1]) off = IDX_W'(i - 1);
    end
    sum = {1'b0, start} + {1'b0, off};
    idx = (sum >= N_EXT) ? IDX_W'(sum - N_EXT) : IDX_W'(sum);
  end

endmodule

// File: rtl/priority_encoder_rr.sv
// N-to-log2(N) priority encoder with fixed or round-robin arbitration and a
// registered valid/ready output stage plus an accepted-grant counter.
module priority_encoder_rr
  import pri_enc_pkg::*;
#(
  parameter  int unsigned N     = 8,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             mode_rr,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot,
  output logic             out_multi,
  output logic [CNT_W-1:0] grant_cnt
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic             load;

  assign load  = !out_valid || out_ready;
  assign start = (mode_rr == MODE_RR) ? ptr : '0;

  pri_find_first #(.N(N)) u_find (
    .vec   (req),
    .start (start),
    .found (found),
    .idx   (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      out_multi  <= 1'b0;
      grant_cnt  <= '0;
      ptr        <= '0;
    end else begin
      if (out_valid && out_ready) grant_cnt <= grant_cnt + 1'b1;
      if (load) begin
        if (found) begin
          out_valid  <= 1'b1;
          out_idx    <= winner;
          out_onehot <= N'(1) << winner;
          out_multi  <= popcount_gt1(PC_MAX_W'(req));
          ptr        <= (winner == IDX_W'(N - 1)) ? '0 : IDX_W'(winner + 1'b1);
        end else begin
          // out_idx deliberately keeps the last granted index
          out_valid  <= 1'b0;
          out_onehot <= '0;
          out_multi  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Directed and random checks of priority_encoder_rr (N=8 and N=5) against a queue-free behavioural model.
module tb_priority_encoder_rr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0]  req8 = '0;
  logic        mode8 = 1'b0, rdy8 = 1'b0;
  logic        v8, mu8;
  logic [2:0]  i8;
  logic [7:0]  oh8;
  logic [15:0] c8;

  logic [4:0]  req5 = '0;
  logic        mode5 = 1'b0, rdy5 = 1'b0;
  logic        v5, mu5;
  logic [2:0]  i5;
  logic [4:0]  oh5;
  logic [3:0]  c5;

  int checks = 0;
  int failures = 0;

  int nn[2]   = '{8, 5};
  int cw[2]   = '{16, 4};
  int mv[2], midx[2], moh[2], mmu[2], mcnt[2], mptr[2];

  always #5 clk = ~clk;

  priority_encoder_rr #(.N(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .mode_rr(mode8), .out_ready(rdy8),
    .out_valid(v8), .out_idx(i8), .out_onehot(oh8), .out_multi(mu8), .grant_cnt(c8)
  );

  priority_encoder_rr #(.N(5), .CNT_W(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .mode_rr(mode5), .out_ready(rdy5),
    .out_valid(v5), .out_idx(i5), .out_onehot(oh5), .out_multi(mu5), .grant_cnt(c5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mv[d] = 0; midx[d] = 0; moh[d] = 0; mmu[d] = 0; mcnt[d] = 0; mptr[d] = 0;
    end
  endtask

  // One clock edge of the specified behaviour: winner by wrap-around search, ptr = winner+1 mod n.
  task automatic model_edge(input int d, input int r, input int mode, input int rdy);
    int n, st, w, ones;
    n = nn[d];
    if (mv[d] != 0 && rdy != 0) mcnt[d] = (mcnt[d] + 1) % (1 << cw[d]);
    if (mv[d] == 0 || rdy != 0) begin
      if (r != 0) begin
        st = (mode != 0) ? mptr[d] : 0;
        w = -1;
        for (int k = 0; k < n; k++)
          if (w < 0 && ((r >> ((st + k) % n)) & 1) != 0) w = (st + k) % n;
        ones = 0;
        for (int k = 0; k < n; k++) ones += (r >> k) & 1;
        mv[d] = 1; midx[d] = w; moh[d] = 1 << w; mmu[d] = (ones > 1);
        mptr[d] = (w + 1) % n;
      end else begin
        mv[d] = 0; moh[d] = 0; mmu[d] = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("valid8", 32'(v8), mv[0]);
    chk("idx8", 32'(i8), midx[0]);
    chk("onehot8", 32'(oh8), moh[0]);
    chk("multi8", 32'(mu8), mmu[0]);
    chk("cnt8", 32'(c8), mcnt[0]);
    chk("valid5", 32'(v5), mv[1]);
    chk("idx5", 32'(i5), midx[1]);
    chk("onehot5", 32'(oh5), moh[1]);
    chk("multi5", 32'(mu5), mmu[1]);
    chk("cnt5", 32'(c5), mcnt[1]);
    chk("idx5_range", 32'(i5 < 3'd5), 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, int'(req8), int'(mode8), int'(rdy8));
    model_edge(1, int'(req5), int'(mode5), int'(rdy5));
    #1;
    check_all();
  endtask

  initial begin
    // Reset held with all requests active: outputs must stay cleared.
    model_reset();
    rst_n = 1'b0; req8 = 8'hFF; req5 = 5'h1F; rdy8 = 1'b1; rdy5 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid8", 32'(v8), 0);
    chk("rst_onehot8", 32'(oh8), 0);
    chk("rst_cnt8", 32'(c8), 0);
    chk("rst_valid5", 32'(v5), 0);
    rst_n = 1'b1;
    step();
    chk("first_idx8", 32'(i8), 0);

    // Fixed priority with multiple requests.
    mode8 = 1'b0; req8 = 8'b1010_0100;
    mode5 = 1'b1; req5 = 5'b10001;
    repeat (4) begin
      step();
      chk("fixed_idx8", 32'(i8), 2);
    end

    // Round-robin sweep with all requests held.
    mode8 = 1'b1; req8 = 8'hFF;
    repeat (9) step();

    // Stall on index 3 while requests change.
    mode8 = 1'b0; req8 = 8'h08;
    step();
    chk("stall_idx8", 32'(i8), 3);
    rdy8 = 1'b0;
    repeat (4) begin
      req8 = 8'($urandom);
      step();
      chk("stall_hold8", 32'(i8), 3);
    end
    rdy8 = 1'b1; req8 = 8'h40;
    step();

    // Empty request on a load for both instances.
    req8 = '0; req5 = '0;
    step();
    step();

    // Drive the 4-bit counter past its wrap point.
    req5 = 5'h1F; mode5 = 1'b1; rdy5 = 1'b1;
    repeat (20) step();

    // Randomised traffic, mode changes included.
    repeat (200) begin
      req8 = 8'($urandom); req5 = 5'($urandom);
      if ($urandom_range(3) == 0) req8 = '0;
      mode8 = 1'($urandom); mode5 = 1'($urandom);
      rdy8 = ($urandom_range(3) != 0); rdy5 = ($urandom_range(3) != 0);
      step();
    end

    // Asynchronous reset between edges while stalled.
    req8 = 8'hFF; req5 = 5'h1F; rdy8 = 1'b1; rdy5 = 1'b1;
    step();
    rdy8 = 1'b0; rdy5 = 1'b0;
    step();
    #3 rst_n = 1'b0;
    #1;
    chk("async_valid8", 32'(v8), 0);
    chk("async_valid5", 32'(v5), 0);
    chk("async_cnt8", 32'(c8), 0);
    model_reset();
    rst_n = 1'b1;
    mode8 = 1'b1; mode5 = 1'b1; rdy8 = 1'b1; rdy5 = 1'b1;
    step();
    chk("restart_idx8", 32'(i8), 0);
    step();
    chk("restart_next8", 32'(i8), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
